// File: rtl/pipeline_mon_pkg.sv
// Shared types for the writeback-commit monitor: FSM states, fail codes and the
// layout of one trace entry.
package pipeline_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PASS = 2'b10,
    ST_FAIL = 2'b11
  } mon_state_e;

  localparam logic [1:0] FAIL_NONE     = 2'b00;
  localparam logic [1:0] FAIL_MISMATCH = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'b10;

  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_IDX_W  = 3;
  localparam int TRACE_DATA_W = 32;

  // Reference layout at the default widths; monitors re-declare it locally at their own widths.
  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_IDX_W-1:0]  dst_idx;
    logic [TRACE_DATA_W-1:0] result;
  } trace_entry_t;

  function automatic int trace_entry_width(input int pc_w, input int idx_w, input int data_w);
    return pc_w + idx_w + data_w;
  endfunction

endpackage

// File: rtl/commit_trace_buf.sv
// Overwrite-oldest ring buffer holding the most recent committed writebacks.
// A push into a full buffer drops the oldest entry and raises a sticky overflow flag.
module commit_trace_buf #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 67,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               ovf_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      // When full, the write slot is the head, so the head must move on whether or not we pop.
      if (do_pop || (push_i && full)) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_i && full && !do_pop) ovf_d = 1'b1;
      if (push_i && !full && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_i && do_pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/pipeline_commit_monitor.sv
// On-chip self-check for the writeback stage: compares commits against a programmable
// expected table, bounds the run with a timeout, and keeps a trace of recent commits.
module pipeline_commit_monitor
  import pipeline_mon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 3,
  parameter int PC_W        = 32,
  parameter int NUM_CHK     = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int TIMEOUT     = 30,
  parameter int ORDERED     = 1,
  localparam int ADDR_W     = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  localparam int TR_W       = trace_entry_width(PC_W, IDX_W, DATA_W),
  localparam int TCNT_W     = $clog2(TRACE_DEPTH) + 1,
  localparam int CYC_W      = $clog2(TIMEOUT + 1),
  localparam int MCH_W      = $clog2(NUM_CHK + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_dst_idx,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [IDX_W-1:0]  exp_dst_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              trace_rd_en,
  output logic [TR_W-1:0]   trace_rd_data,
  output logic              trace_empty,
  output logic [TCNT_W-1:0] trace_count,
  output logic              trace_ovf,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [MCH_W-1:0]  match_count
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [IDX_W-1:0]  dst_idx;
    logic [DATA_W-1:0] result;
  } entry_t;

  mon_state_e        state_q, state_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic [MCH_W-1:0]  match_q, match_d;
  logic [1:0]        fail_q, fail_d;
  logic [IDX_W-1:0]  exp_idx_q  [NUM_CHK];
  logic [DATA_W-1:0] exp_data_q [NUM_CHK];
  logic [ADDR_W-1:0] cur_addr;
  logic              running, hit, final_hit, miss, timed_out;
  entry_t            push_entry;

  assign running  = (state_q == ST_RUN);
  assign cur_addr = match_q[ADDR_W-1:0];
  assign hit      = (wb_dst_idx == exp_idx_q[cur_addr]) && (wb_result == exp_data_q[cur_addr]);

  // The table has no reset; it is reloaded by software before each run.
  always_ff @(posedge clk) begin
    if (exp_we && !running && (int'(exp_addr) < NUM_CHK)) begin
      exp_idx_q[exp_addr]  <= exp_dst_idx;
      exp_data_q[exp_addr] <= exp_data;
    end
  end

  assign final_hit = wb_valid && hit && (match_q == MCH_W'(NUM_CHK - 1));
  assign miss      = wb_valid && !hit && (ORDERED != 0);
  assign timed_out = (cycle_d == CYC_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    match_d = match_q;
    fail_d  = fail_q;
    if (start) begin
      state_d = ST_RUN;
      cycle_d = '0;
      match_d = '0;
      fail_d  = FAIL_NONE;
    end else if (running) begin
      if (cycle_q != CYC_W'(TIMEOUT)) cycle_d = cycle_q + CYC_W'(1);
      if (wb_valid && hit) match_d = match_q + MCH_W'(1);
      if (final_hit) begin
        state_d = ST_PASS;
      end else if (miss) begin
        state_d = ST_FAIL;
        fail_d  = FAIL_MISMATCH;
      end else if (timed_out) begin
        state_d = ST_FAIL;
        fail_d  = FAIL_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
      match_q <= '0;
      fail_q  <= FAIL_NONE;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      match_q <= match_d;
      fail_q  <= fail_d;
    end
  end

  assign push_entry = '{pc: wb_pc, dst_idx: wb_dst_idx, result: wb_result};

  commit_trace_buf #(
    .DEPTH   (TRACE_DEPTH),
    .ENTRY_W (TR_W)
  ) u_trace (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (start),
    .push_i      (running && wb_valid && !start),
    .push_data_i (push_entry),
    .pop_i       (trace_rd_en),
    .rd_data_o   (trace_rd_data),
    .empty_o     (trace_empty),
    .count_o     (trace_count),
    .ovf_o       (trace_ovf)
  );

  assign busy        = running;
  assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass        = (state_q == ST_PASS);
  assign fail_code   = fail_q;
  assign cycle_count = cycle_q;
  assign match_count = match_q;

endmodule

// File: tb/tb_pipeline_commit_monitor.sv
// Directed bench: an ordered 4-entry monitor (A) and a search-mode 1-entry monitor
// with a 4-deep trace (B), sharing the writeback tap.
module tb_pipeline_commit_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startA = 1'b0, startB = 1'b0;
  logic        wbValid = 1'b0;
  logic [2:0]  wbDst = '0;
  logic [31:0] wbResult = '0, wbPc = '0;
  logic        expWeA = 1'b0, expWeB = 1'b0;
  logic [1:0]  expAddr = '0;
  logic [2:0]  expDst = '0;
  logic [31:0] expData = '0;
  logic        trRdA = 1'b0, trRdB = 1'b0;

  logic [66:0] rdDataA, rdDataB;
  logic        emptyA, emptyB, ovfA, ovfB;
  logic [4:0]  tCountA;
  logic [2:0]  tCountB;
  logic        busyA, busyB, doneA, doneB, passA, passB;
  logic [1:0]  failA, failB;
  logic [4:0]  cycA, cycB;
  logic [2:0]  matchA;
  logic        matchB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  pipeline_commit_monitor #(
    .DATA_W(32), .IDX_W(3), .PC_W(32), .NUM_CHK(4),
    .TRACE_DEPTH(16), .TIMEOUT(30), .ORDERED(1)
  ) u_dutA (
    .clk(clk), .rst(rst), .start(startA),
    .wb_valid(wbValid), .wb_dst_idx(wbDst), .wb_result(wbResult), .wb_pc(wbPc),
    .exp_we(expWeA), .exp_addr(expAddr), .exp_dst_idx(expDst), .exp_data(expData),
    .trace_rd_en(trRdA), .trace_rd_data(rdDataA), .trace_empty(emptyA),
    .trace_count(tCountA), .trace_ovf(ovfA),
    .busy(busyA), .done(doneA), .pass(passA), .fail_code(failA),
    .cycle_count(cycA), .match_count(matchA)
  );

  pipeline_commit_monitor #(
    .DATA_W(32), .IDX_W(3), .PC_W(32), .NUM_CHK(1),
    .TRACE_DEPTH(4), .TIMEOUT(30), .ORDERED(0)
  ) u_dutB (
    .clk(clk), .rst(rst), .start(startB),
    .wb_valid(wbValid), .wb_dst_idx(wbDst), .wb_result(wbResult), .wb_pc(wbPc),
    .exp_we(expWeB), .exp_addr(expAddr[0]), .exp_dst_idx(expDst), .exp_data(expData),
    .trace_rd_en(trRdB), .trace_rd_data(rdDataB), .trace_empty(emptyB),
    .trace_count(tCountB), .trace_ovf(ovfB),
    .busy(busyB), .done(doneB), .pass(passB), .fail_code(failB),
    .cycle_count(cycB), .match_count(matchB)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // One writeback commit lasting a single cycle.
  task automatic applyStimulus(input logic [2:0] dst, input logic [31:0] result, input logic [31:0] pc);
    wbValid  = 1'b1;
    wbDst    = dst;
    wbResult = result;
    wbPc     = pc;
    stepCycle();
    wbValid  = 1'b0;
  endtask

  task automatic writeExp(input logic toA, input logic [1:0] addr, input logic [2:0] dst, input logic [31:0] data);
    expWeA  = toA;
    expWeB  = !toA;
    expAddr = addr;
    expDst  = dst;
    expData = data;
    stepCycle();
    expWeA  = 1'b0;
    expWeB  = 1'b0;
  endtask

  task automatic pulseStart(input logic toA);
    startA = toA;
    startB = !toA;
    stepCycle();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic loadTableA();
    writeExp(1'b1, 2'd0, 3'd0, 32'd1);
    writeExp(1'b1, 2'd1, 3'd1, 32'd2);
    writeExp(1'b1, 2'd2, 3'd0, 32'd3);
    writeExp(1'b1, 2'd3, 3'd1, 32'd4);
  endtask

  initial begin
    logic [66:0] expEntry;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy", 128'(busyA), 128'(1'b0));
    checkOutput("reset done", 128'(doneA), 128'(1'b0));
    checkOutput("reset pass", 128'(passA), 128'(1'b0));
    checkOutput("reset fail_code", 128'(failA), 128'(2'd0));
    checkOutput("reset cycle_count", 128'(cycA), 128'(5'd0));
    checkOutput("reset match_count", 128'(matchA), 128'(3'd0));
    checkOutput("reset trace_count", 128'(tCountA), 128'(5'd0));
    checkOutput("reset trace_ovf", 128'(ovfA), 128'(1'b0));
    checkOutput("reset trace_rd_data", 128'(rdDataA), 128'(67'd0));
    rst = 1'b1;
    stepCycle();

    loadTableA();
    writeExp(1'b0, 2'd0, 3'd0, 32'h12341233);

    $display("[TB] search-mode pass with unrelated commits");
    pulseStart(1'b0);
    idle(1);
    applyStimulus(3'd1, 32'd5, 32'd100);
    idle(1);
    applyStimulus(3'd0, 32'd7, 32'd104);
    idle(5);
    checkOutput("B busy before match", 128'(busyB), 128'(1'b1));
    checkOutput("B pass before match", 128'(passB), 128'(1'b0));
    checkOutput("B cycle_count at 9", 128'(cycB), 128'(5'd9));
    applyStimulus(3'd0, 32'h12341233, 32'd108);
    checkOutput("B pass", 128'(passB), 128'(1'b1));
    checkOutput("B done", 128'(doneB), 128'(1'b1));
    checkOutput("B busy after pass", 128'(busyB), 128'(1'b0));
    checkOutput("B match_count", 128'(matchB), 128'(1'b1));
    checkOutput("B trace_count", 128'(tCountB), 128'(3'd3));
    checkOutput("B cycle_count at pass", 128'(cycB), 128'(5'd10));
    expEntry = {32'd100, 3'd1, 32'd5};
    checkOutput("B oldest trace entry", 128'(rdDataB), 128'(expEntry));
    checkOutput("A idle not traced", 128'(tCountA), 128'(5'd0));

    $display("[TB] ordered mismatch");
    pulseStart(1'b1);
    applyStimulus(3'd0, 32'd1, 32'd0);
    checkOutput("A match after first", 128'(matchA), 128'(3'd1));
    checkOutput("A busy after first", 128'(busyA), 128'(1'b1));
    applyStimulus(3'd1, 32'd9, 32'd4);
    checkOutput("A done on mismatch", 128'(doneA), 128'(1'b1));
    checkOutput("A pass on mismatch", 128'(passA), 128'(1'b0));
    checkOutput("A fail_code mismatch", 128'(failA), 128'(2'b01));
    checkOutput("A match on mismatch", 128'(matchA), 128'(3'd1));
    checkOutput("A trace_count mismatch", 128'(tCountA), 128'(5'd2));
    checkOutput("B sticky pass ignores commits", 128'(tCountB), 128'(3'd3));

    $display("[TB] timeout");
    pulseStart(1'b1);
    idle(29);
    checkOutput("A busy at 29", 128'(busyA), 128'(1'b1));
    checkOutput("A cycle_count at 29", 128'(cycA), 128'(5'd29));
    idle(1);
    checkOutput("A fail_code timeout", 128'(failA), 128'(2'b10));
    checkOutput("A cycle_count timeout", 128'(cycA), 128'(5'd30));
    checkOutput("A done timeout", 128'(doneA), 128'(1'b1));
    idle(3);
    checkOutput("A cycle_count holds", 128'(cycA), 128'(5'd30));
    checkOutput("A fail_code sticky", 128'(failA), 128'(2'b10));

    $display("[TB] trace overflow and drain");
    pulseStart(1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(3'd2, 32'(i), 32'(i));
    checkOutput("B trace_ovf", 128'(ovfB), 128'(1'b1));
    checkOutput("B trace_count full", 128'(tCountB), 128'(3'd4));
    checkOutput("B still busy", 128'(busyB), 128'(1'b1));
    trRdB = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("B pop pc %0d", k), 128'(rdDataB[66:35]), 128'(k + 2));
      stepCycle();
    end
    stepCycle();
    trRdB = 1'b0;
    checkOutput("B trace_empty after drain", 128'(emptyB), 128'(1'b1));
    checkOutput("B trace_count after drain", 128'(tCountB), 128'(3'd0));
    pulseStart(1'b0);
    checkOutput("B trace_ovf cleared on start", 128'(ovfB), 128'(1'b0));

    $display("[TB] final match on timeout cycle");
    pulseStart(1'b1);
    applyStimulus(3'd0, 32'd1, 32'd0);
    applyStimulus(3'd1, 32'd2, 32'd4);
    applyStimulus(3'd0, 32'd3, 32'd8);
    idle(26);
    checkOutput("A match before final", 128'(matchA), 128'(3'd3));
    checkOutput("A cycle before final", 128'(cycA), 128'(5'd29));
    applyStimulus(3'd1, 32'd4, 32'd12);
    checkOutput("A pass at timeout", 128'(passA), 128'(1'b1));
    checkOutput("A fail_code at timeout pass", 128'(failA), 128'(2'b00));
    checkOutput("A match final", 128'(matchA), 128'(3'd4));
    checkOutput("A cycle final", 128'(cycA), 128'(5'd30));

    $display("[TB] restart mid-run");
    pulseStart(1'b1);
    applyStimulus(3'd0, 32'd1, 32'd0);
    idle(2);
    checkOutput("A match pre-restart", 128'(matchA), 128'(3'd1));
    checkOutput("A trace pre-restart", 128'(tCountA), 128'(5'd1));
    checkOutput("A cycle pre-restart", 128'(cycA), 128'(5'd3));
    startA = 1'b1;
    applyStimulus(3'd1, 32'd2, 32'd4);
    startA = 1'b0;
    checkOutput("A cycle after restart", 128'(cycA), 128'(5'd0));
    checkOutput("A match after restart", 128'(matchA), 128'(3'd0));
    checkOutput("A trace after restart", 128'(tCountA), 128'(5'd0));
    checkOutput("A busy after restart", 128'(busyA), 128'(1'b1));

    $display("[TB] table writes ignored in run");
    writeExp(1'b1, 2'd0, 3'd5, 32'd99);
    writeExp(1'b1, 2'd3, 3'd6, 32'd77);
    pulseStart(1'b1);
    applyStimulus(3'd0, 32'd1, 32'd0);
    applyStimulus(3'd1, 32'd2, 32'd4);
    applyStimulus(3'd0, 32'd3, 32'd8);
    applyStimulus(3'd1, 32'd4, 32'd12);
    checkOutput("A pass with original table", 128'(passA), 128'(1'b1));
    checkOutput("A match with original table", 128'(matchA), 128'(3'd4));

    $display("[TB] asynchronous reset mid-run");
    pulseStart(1'b1);
    applyStimulus(3'd0, 32'd1, 32'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("A busy in reset", 128'(busyA), 128'(1'b0));
    checkOutput("A done in reset", 128'(doneA), 128'(1'b0));
    checkOutput("A match in reset", 128'(matchA), 128'(3'd0));
    checkOutput("A cycle in reset", 128'(cycA), 128'(5'd0));
    checkOutput("A trace in reset", 128'(tCountA), 128'(5'd0));
    checkOutput("A fail_code in reset", 128'(failA), 128'(2'd0));
    checkOutput("B done in reset", 128'(doneB), 128'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
